// File: rtl/harvard_bus_pkg.sv
// Shared types and constants for the Harvard-core-to-shared-bus sequencer.
package harvard_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_DATA_RD,
        ST_DATA_WR,
        ST_COMMIT,
        ST_HALT
    } arb_state_t;

    localparam logic [3:0]  BYTEEN_ALL = 4'hF;
    localparam logic [31:0] WORD_MASK  = 32'hFFFFFFFC;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/harvard_bus_arbiter.sv
// Serialises a Harvard core's fetch and data accesses onto one wait-stated bus,
// latching results and releasing the core's clock enable once per instruction.
module harvard_bus_arbiter
    import harvard_bus_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_clk_enable,
    input  logic        cpu_active,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic [31:0] cpu_data_writedata,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    output logic [31:0] cpu_data_readdata,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        halted,
    output logic [31:0] instr_count
);

    arb_state_t state, next_state;
    logic       accept;

    assign accept         = !bus_waitrequest;
    assign bus_byteenable = BYTEEN_ALL;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // The core is frozen between commits, so its addresses are stable and can
    // be muxed straight onto the bus while a request waits.
    always_comb begin
        next_state  = state;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        bus_address = RESET_VECTOR;
        case (state)
            ST_IDLE:   next_state = ST_FETCH;
            ST_FETCH: begin
                bus_read    = 1'b1;
                bus_address = word_addr(cpu_instr_address);
                if (accept) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (cpu_data_read)       next_state = ST_DATA_RD;
                else if (cpu_data_write) next_state = ST_DATA_WR;
                else                     next_state = ST_COMMIT;
            end
            ST_DATA_RD: begin
                bus_read    = 1'b1;
                bus_address = word_addr(cpu_data_address);
                if (accept) next_state = cpu_data_write ? ST_DATA_WR : ST_COMMIT;
            end
            ST_DATA_WR: begin
                bus_write   = 1'b1;
                bus_address = word_addr(cpu_data_address);
                if (accept) next_state = ST_COMMIT;
            end
            ST_COMMIT: next_state = cpu_active ? ST_FETCH : ST_HALT;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_clk_enable = (state == ST_COMMIT);
        halted         = (state == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_instr_readdata <= '0;
            cpu_data_readdata  <= '0;
            bus_writedata      <= '0;
            instr_count        <= '0;
        end else begin
            if (state == ST_FETCH && accept)   cpu_instr_readdata <= bus_readdata;
            if (state == ST_DATA_RD && accept) cpu_data_readdata  <= bus_readdata;
            // Captured once on entry so the write word stays put across wait-states.
            if (next_state == ST_DATA_WR && state != ST_DATA_WR)
                bus_writedata <= cpu_data_writedata;
            if (state == ST_COMMIT) instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_harvard_bus_arbiter.sv
// Directed bench: the core is played by hand-set strobes and addresses per instruction.
module tb_harvard_bus_arbiter;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_clk_enable;
    logic        cpu_active;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic [31:0] cpu_data_writedata;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_readdata;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        halted;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    harvard_bus_arbiter #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset),
        .cpu_clk_enable(cpu_clk_enable), .cpu_active(cpu_active),
        .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(cpu_instr_readdata),
        .cpu_data_address(cpu_data_address), .cpu_data_writedata(cpu_data_writedata),
        .cpu_data_read(cpu_data_read), .cpu_data_write(cpu_data_write),
        .cpu_data_readdata(cpu_data_readdata),
        .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
        .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
        .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_count;
        int ce_at;
        int quiet;

        reset = 1'b0; cpu_active = 1'b1;
        cpu_instr_address = RV; cpu_data_address = '0; cpu_data_writedata = '0;
        cpu_data_read = 1'b0; cpu_data_write = 1'b0;
        bus_waitrequest = 1'b0; bus_readdata = '0;

        // Reset values
        repeat (3) tick;
        chk("rst_read", {31'd0, bus_read}, 0);
        chk("rst_write", {31'd0, bus_write}, 0);
        chk("rst_addr", bus_address, RV);
        chk("rst_wdata", bus_writedata, 0);
        chk("rst_ce", {31'd0, cpu_clk_enable}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_ird", cpu_instr_readdata, 0);
        chk("rst_drd", cpu_data_readdata, 0);
        chk("rst_cnt", instr_count, 0);
        chk("byteen", {28'd0, bus_byteenable}, 32'hF);

        // IDLE one cycle, then first fetch (nop, zero wait)
        reset = 1'b1; #1;
        chk("idle_read", {31'd0, bus_read}, 0);
        chk("idle_addr", bus_address, RV);
        tick;
        chk("f1_read", {31'd0, bus_read}, 1);
        chk("f1_addr", bus_address, RV);
        tick;
        chk("d1_read", {31'd0, bus_read}, 0);
        chk("d1_ce", {31'd0, cpu_clk_enable}, 0);
        tick;
        chk("c1_ce", {31'd0, cpu_clk_enable}, 1);

        // addiu fetch with 4 wait-states
        cpu_instr_address = RV + 32'd4; bus_waitrequest = 1'b1; bus_readdata = 32'h24080005;
        tick;
        chk("cnt1", instr_count, 1);
        ce_count = 0; ce_at = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 5) begin bus_waitrequest = 1'b0; #1; end
            if (c <= 4) begin
                chk("ws_read", {31'd0, bus_read}, 1);
                chk("ws_addr", bus_address, RV + 32'd4);
            end
            if (cpu_clk_enable) begin ce_count++; ce_at = c; end
            if (c < 7) tick;
        end
        chk("ws_ce_count", ce_count, 1);
        chk("ws_ce_at", ce_at, 7);
        chk("ws_ird", cpu_instr_readdata, 32'h24080005);

        // lw from unaligned-looking address 0x1006
        cpu_instr_address = RV + 32'd8; bus_readdata = 32'h8C091006;
        cpu_data_read = 1'b1; cpu_data_address = 32'h00001006;
        tick;
        chk("ld_iaddr", bus_address, RV + 32'd8);
        tick;
        bus_readdata = 32'hDEADBEEF;
        chk("ld_dec_read", {31'd0, bus_read}, 0);
        tick;
        chk("ld_rd_read", {31'd0, bus_read}, 1);
        chk("ld_rd_addr", bus_address, 32'h00001004);
        tick;
        chk("ld_ce", {31'd0, cpu_clk_enable}, 1);
        chk("ld_drd", cpu_data_readdata, 32'hDEADBEEF);
        chk("ld_ird", cpu_instr_readdata, 32'h8C091006);

        // sb: read-modify-write, core's merged word is 0x1122AA44
        cpu_instr_address = RV + 32'd12; bus_readdata = 32'hA00A2001;
        cpu_data_read = 1'b1; cpu_data_write = 1'b1;
        cpu_data_address = 32'h00002001; cpu_data_writedata = 32'h1122AA44;
        tick;
        chk("rmw_f_excl", {31'd0, bus_read & bus_write}, 0);
        tick;
        bus_readdata = 32'h11223344;
        chk("rmw_d_excl", {31'd0, bus_read | bus_write}, 0);
        tick;
        chk("rmw_rd_read", {31'd0, bus_read}, 1);
        chk("rmw_rd_write", {31'd0, bus_write}, 0);
        chk("rmw_rd_addr", bus_address, 32'h00002000);
        tick;
        chk("rmw_wr_write", {31'd0, bus_write}, 1);
        chk("rmw_wr_read", {31'd0, bus_read}, 0);
        chk("rmw_wr_addr", bus_address, 32'h00002000);
        chk("rmw_wdata", bus_writedata, 32'h1122AA44);
        chk("rmw_drd", cpu_data_readdata, 32'h11223344);
        tick;
        chk("rmw_ce", {31'd0, cpu_clk_enable}, 1);
        chk("rmw_c_excl", {31'd0, bus_read | bus_write}, 0);

        // sw with 2 write wait-states; write data must hold even if core changes it
        cpu_instr_address = RV + 32'd16; bus_readdata = 32'hAC0B3000;
        cpu_data_read = 1'b0; cpu_data_write = 1'b1;
        cpu_data_address = 32'h00003000; cpu_data_writedata = 32'hCAFEF00D;
        tick;
        tick;
        bus_waitrequest = 1'b1;
        tick;
        cpu_data_writedata = 32'h0; #1;
        chk("sw_w1_write", {31'd0, bus_write}, 1);
        chk("sw_w1_wdata", bus_writedata, 32'hCAFEF00D);
        chk("sw_w1_addr", bus_address, 32'h00003000);
        tick;
        chk("sw_w2_write", {31'd0, bus_write}, 1);
        chk("sw_w2_wdata", bus_writedata, 32'hCAFEF00D);
        chk("sw_w2_ce", {31'd0, cpu_clk_enable}, 0);
        tick;
        bus_waitrequest = 1'b0; #1;
        chk("sw_w3_write", {31'd0, bus_write}, 1);
        tick;
        chk("sw_ce", {31'd0, cpu_clk_enable}, 1);
        chk("sw_drd_kept", cpu_data_readdata, 32'h11223344);

        // jr to 0: core drops active before commit
        cpu_instr_address = RV + 32'd20; bus_readdata = 32'h03E00008;
        cpu_data_write = 1'b0;
        tick;
        tick;
        cpu_active = 1'b0;
        tick;
        chk("hlt_ce", {31'd0, cpu_clk_enable}, 1);
        tick;
        chk("hlt_halted", {31'd0, halted}, 1);
        chk("hlt_cnt", instr_count, 6);
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus_read || bus_write || cpu_clk_enable) quiet++;
            tick;
        end
        chk("hlt_quiet", quiet, 0);
        chk("hlt_still", {31'd0, halted}, 1);
        reset = 1'b0;
        tick;
        chk("hrst_halted", {31'd0, halted}, 0);
        chk("hrst_addr", bus_address, RV);
        chk("hrst_cnt", instr_count, 0);
        chk("hrst_drd", cpu_data_readdata, 0);
        chk("hrst_ird", cpu_instr_readdata, 0);
        chk("hrst_wdata", bus_writedata, 0);

        // Reset while a data read is stalled
        reset = 1'b1; cpu_active = 1'b1;
        cpu_instr_address = RV; bus_readdata = 32'h8C091006;
        cpu_data_read = 1'b1; cpu_data_address = 32'h00001006;
        #1;
        tick;
        chk("mr_f_read", {31'd0, bus_read}, 1);
        tick;
        bus_waitrequest = 1'b1; bus_readdata = 32'h55555555;
        tick;
        chk("mr_rd_read", {31'd0, bus_read}, 1);
        chk("mr_rd_addr", bus_address, 32'h00001004);
        reset = 1'b0;
        tick;
        chk("mr_read", {31'd0, bus_read}, 0);
        chk("mr_write", {31'd0, bus_write}, 0);
        chk("mr_addr", bus_address, RV);
        chk("mr_ird", cpu_instr_readdata, 0);
        chk("mr_drd", cpu_data_readdata, 0);
        chk("mr_cnt", instr_count, 0);
        chk("mr_ce", {31'd0, cpu_clk_enable}, 0);
        chk("mr_halted", {31'd0, halted}, 0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/harvard_bus_arbiter.md
# harvard_bus_arbiter

Sequencer that lets one `mips_cpu_harvard` core run on a single shared memory bus with wait-states. It serialises each instruction fetch and data access onto the bus. It latches the results and presents them to the core's combinational instruction and data read ports. It pulses the core's `clk_enable` once per instruction, only after every access that instruction needs has completed.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000: value `bus_address` holds during reset and IDLE.

Ports:
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `cpu_clk_enable`  out  1  drives the core's `clk_enable`; high for exactly one cycle per instruction.
- `cpu_active`  in  1  core's `active` output.
- `cpu_instr_address`  in  32  core's instruction address.
- `cpu_instr_readdata`  out  32  latched instruction word.
- `cpu_data_address`, `cpu_data_writedata`  in  32  core's data port.
- `cpu_data_read`, `cpu_data_write`  in  1  core's data strobes.
- `cpu_data_readdata`  out  32  latched data word.
- `bus_address`  out  32  word-aligned address, {addr[31:2],2'b00}.
- `bus_read`, `bus_write`  out  1  request strobes; never high together.
- `bus_byteenable`  out  4  constant 4'hF.
- `bus_writedata`  out  32  registered copy of `cpu_data_writedata`.
- `bus_waitrequest`  in  1  high = request not yet accepted.
- `bus_readdata`  in  32  valid in the cycle a read has `bus_waitrequest`=0.
- `halted`  out  1  high in HALT.
- `instr_count`  out  32  number of committed instructions; wraps at 2^32.

## Operation
States: IDLE, FETCH, DECODE, DATA_RD, DATA_WR, COMMIT, HALT.

- **IDLE:** entered on reset. Lasts one cycle, then goes to FETCH.
- **FETCH:**
  - Drives `bus_read`=1 with `bus_address` taken from `cpu_instr_address`.
  - On `bus_waitrequest`=0: `cpu_instr_readdata` <= `bus_readdata`, then go to DECODE.
- **DECODE:**
  - The latched instruction is stable, so the core's data strobes are valid. No bus activity.
  - If `cpu_data_read` is high, go to DATA_RD.
  - Otherwise, if `cpu_data_write` is high, go to DATA_WR.
  - Otherwise, go to COMMIT.
- **DATA_RD:**
  - Drives `bus_read` with `bus_address` taken from `cpu_data_address`.
  - On accept: `cpu_data_readdata` <= `bus_readdata`.
  - Then go to DATA_WR if `cpu_data_write` is high (sub-word store read-modify-write; the core derives `data_writedata` from `cpu_data_readdata`). Otherwise go to COMMIT.
- **DATA_WR:**
  - On entry, captures `cpu_data_writedata` into `bus_writedata`.
  - Drives `bus_write` until accepted, then goes to COMMIT.
- **COMMIT:**
  - `cpu_clk_enable`=1 for one cycle and `instr_count` increments.
  - Next state is FETCH if `cpu_active`=1, otherwise HALT.
- **HALT:**
  - All strobes are 0 and `halted`=1.
  - Only reset exits this state.

Rules:
- While `bus_waitrequest`=1, the bus address, strobes and write data are held stable.
- `cpu_clk_enable` is 0 in every state except COMMIT.
- Reset mid-transaction:
  - Strobes drop at the next edge.
  - The abandoned bus cycle is not completed.
  - Latched data is cleared.

## Timing
- Reset values:
  - State IDLE.
  - All strobes 0; `cpu_clk_enable`=0; `halted`=0.
  - `bus_address`=`RESET_VECTOR`; `bus_writedata`=0.
  - `cpu_instr_readdata`=0; `cpu_data_readdata`=0; `instr_count`=0.
- Cycles per instruction with zero wait-states:
  - ALU or branch: 3 (FETCH, DECODE, COMMIT).
  - Load or word store: 4.
  - Read-modify-write store: 5.
- Each wait-state cycle adds 1 to the cycle count.
- `cpu_instr_readdata` and `cpu_data_readdata` change only at a FETCH or DATA_RD accept edge, or at reset. Both stay stable through COMMIT.
- The core's reset must be held while this block's `reset` is low. The core sets `active` during reset, so `cpu_active` is already high at the first COMMIT.

## Structure
- Package `harvard_bus_pkg`:
  - `arb_state_t` enum (7 states).
  - `BYTEEN_ALL` = 4'hF.
  - `WORD_MASK` = 32'hFFFFFFFC.
- Single FSM module, no sub-module. The next-state logic and the bus-drive mux are one always_comb block.
- A top-level wrapper instantiates the core, this block and the memory.

## Test plan
- **Reset and first fetch:** reset=0 for 3 cycles, then release, bus returns 32'h00000000 immediately.
  - Required: FETCH asserts `bus_read` at `RESET_VECTOR` one cycle after IDLE.
  - Required: COMMIT pulse in cycle 3 after FETCH start; `instr_count`=1.
- **Wait-states:** addiu fetch with `bus_waitrequest` high for 4 cycles.
  - Required: `bus_read` and `bus_address` held stable for all 4 cycles.
  - Required: `cpu_clk_enable` pulses exactly once, 7 cycles after FETCH entry.
- **Load:** lw fetched, `cpu_data_read`=1 at address 32'h00001006, bus returns 32'hDEADBEEF.
  - Required: `bus_address`=32'h00001004.
  - Required: `cpu_data_readdata`=32'hDEADBEEF through COMMIT; 4 cycles total.
- **Read-modify-write store:** sb with both strobes high.
  - Required: DATA_RD then DATA_WR; `bus_read` and `bus_write` never high together.
  - Required: `bus_writedata` equals the core's merged word; 5 cycles total.
- **Halt:** jr to 0, so `cpu_active` falls before COMMIT ends.
  - Required: HALT, `halted`=1, no further bus strobes for 20 cycles.
  - Required: reset pulse returns to IDLE.
- **Reset mid-DATA_RD:** reset asserted while `bus_waitrequest`=1.
  - Required: `bus_read`=0 on the next edge; all outputs at reset values.
